// File: rtl/pmod_cls_multi_spi_solo.sv
// pmod_cls_multi_spi_solo: sequences clear/write command bytes for a PMOD CLS display into an SPI TX FIFO.
// Latency: a request is taken one enable after IDLE; bytes leave one per enable while i_tx_ready is high.
// Backpressure: a low i_tx_ready freezes the RUN state and byte index; o_tx_enqueue follows i_tx_ready and is consumed on enable cycles.
// Optional macro PMOD_CLS_BOOT_CLEAR_EN: after the boot wait, issue one display clear before accepting commands.
module pmod_cls_multi_spi_solo #(
  parameter int parm_fast_simulation = 0,
  parameter int parm_FCLK_ce         = 2500000,
  parameter int parm_lines           = 2,
  parameter int parm_line_chars      = 16
) (
  input  logic                         i_ext_spi_clk_x,
  input  logic                         i_srst,
  input  logic                         i_spi_ce_4x,
  output logic                         o_command_ready,
  input  logic                         i_cmd_clear,
  input  logic                         i_cmd_write,
  input  logic [1:0]                   i_row,
  input  logic [5:0]                   i_col,
  input  logic [5:0]                   i_len,
  input  logic [8*parm_line_chars-1:0] i_dat_ascii,
  output logic                         o_cmd_error,
  output logic [7:0]                   o_tx_data,
  output logic                         o_tx_enqueue,
  input  logic                         i_tx_ready,
  output logic [7:0]                   o_tx_len,
  output logic                         o_go_stand,
  output logic [7:0]                   o_rx_len,
  output logic [7:0]                   o_wait_cyc,
  output logic                         o_rx_dequeue,
  input  logic                         i_spi_idle
);

  localparam int          TW         = 8 * parm_line_chars;
  localparam int          BOOT_MULT  = (parm_fast_simulation != 0) ? 2 : 800;
  localparam logic [23:0] BOOT_LAST  = 24'(parm_FCLK_ce / 1000 * BOOT_MULT - 1);
  localparam logic [6:0]  LINE_CHARS = 7'(parm_line_chars);
  localparam logic [2:0]  LINES      = 3'(parm_lines);
  localparam logic [55:0] CLR_SEQ    = {8'h1B, 8'h5B, 8'h30, 8'h6A, 24'h0};

  typedef enum logic [3:0] {
    ST_BOOT     = 4'd0,
`ifdef PMOD_CLS_BOOT_CLEAR_EN
    ST_INIT_CLR = 4'd1,
`endif
    ST_IDLE     = 4'd2,
    ST_LOAD_CLR = 4'd3,
    ST_LOAD_TXT = 4'd4,
    ST_CMD_RUN  = 4'd5,
    ST_CMD_WAIT = 4'd6,
    ST_DAT_RUN  = 4'd7,
    ST_DAT_WAIT = 4'd8
  } state_t;

  state_t          state_q, state_d;
  logic [23:0]     timer_q, timer_d;
  logic [55:0]     cmd_q, cmd_d;       // command bytes, next byte in the MSBs
  logic [7:0]      cmd_len_q, cmd_len_d;
  logic [TW-1:0]   text_q, text_d;     // text pre-shifted so the next char is in the MSBs
  logic [5:0]      rem_q, rem_d;       // bytes left in the current transfer
  logic [5:0]      n_q, n_d;           // data characters of the pending write
  logic            err_q, err_d;

  logic            wr_ok;
  logic [6:0]      avail;
  logic [5:0]      n_clip;
  logic [5:0]      col_tens, col_ones;
  logic [55:0]     wr_seq;

  // Request validation and the write command header, derived from live inputs
  always_comb begin
    wr_ok    = ({1'b0, i_row} < LINES) && ({1'b0, i_col} < LINE_CHARS) && (i_len != 6'd0);
    avail    = LINE_CHARS - {1'b0, i_col};
    n_clip   = ({1'b0, i_len} > avail) ? avail[5:0] : i_len;
    col_tens = i_col / 6'd10;
    col_ones = i_col % 6'd10;
    wr_seq   = {8'h1B, 8'h5B, 8'h30 + {6'b0, i_row}, 8'h3B,
                8'h30 + {2'b0, col_tens}, 8'h30 + {2'b0, col_ones}, 8'h48};
  end

  // Next-state, datapath updates and TX outputs
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    cmd_d        = cmd_q;
    cmd_len_d    = cmd_len_q;
    text_d       = text_q;
    rem_d        = rem_q;
    n_d          = n_q;
    err_d        = err_q;
    o_tx_data    = 8'h00;
    o_tx_enqueue = 1'b0;
    o_tx_len     = 8'h00;
    o_go_stand   = 1'b0;

    // error pulse lasts exactly one enable period
    if (i_spi_ce_4x) err_d = 1'b0;

    case (state_q)
      ST_BOOT: begin
        if (i_spi_ce_4x) begin
          if (timer_q == BOOT_LAST) begin
`ifdef PMOD_CLS_BOOT_CLEAR_EN
            state_d = ST_INIT_CLR;
`else
            state_d = ST_IDLE;
`endif
          end else begin
            timer_d = timer_q + 24'd1;
          end
        end
      end

      ST_IDLE: begin
        if (i_spi_ce_4x) begin
          if (i_cmd_clear) begin
            state_d = ST_LOAD_CLR;
          end else if (i_cmd_write) begin
            if (wr_ok) state_d = ST_LOAD_TXT;
            else       err_d   = 1'b1;
          end
        end
      end

`ifdef PMOD_CLS_BOOT_CLEAR_EN
      ST_INIT_CLR,
`endif
      ST_LOAD_CLR: begin
        if (i_spi_ce_4x) begin
          cmd_d     = CLR_SEQ;
          cmd_len_d = 8'd4;
          rem_d     = 6'd4;
          n_d       = 6'd0;
          state_d   = ST_CMD_RUN;
        end
      end

      ST_LOAD_TXT: begin
        // snapshot everything here so later input changes cannot leak in
        if (i_spi_ce_4x) begin
          cmd_d     = wr_seq;
          cmd_len_d = 8'd7;
          rem_d     = 6'd7;
          n_d       = n_clip;
          text_d    = i_dat_ascii << {i_col, 3'b000};
          state_d   = ST_CMD_RUN;
        end
      end

      ST_CMD_RUN: begin
        o_tx_data    = cmd_q[55:48];
        o_tx_enqueue = i_tx_ready;
        o_tx_len     = cmd_len_q;
        o_go_stand   = i_tx_ready && (rem_q == 6'd1);
        if (i_spi_ce_4x && i_tx_ready) begin
          cmd_d = cmd_q << 8;
          rem_d = rem_q - 6'd1;
          if (rem_q == 6'd1) state_d = ST_CMD_WAIT;
        end
      end

      ST_CMD_WAIT: begin
        if (i_spi_ce_4x && i_spi_idle) begin
          if (n_q != 6'd0) begin
            rem_d   = n_q;
            state_d = ST_DAT_RUN;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_DAT_RUN: begin
        o_tx_data    = text_q[TW-1 -: 8];
        o_tx_enqueue = i_tx_ready;
        o_tx_len     = {2'b00, n_q};
        o_go_stand   = i_tx_ready && (rem_q == 6'd1);
        if (i_spi_ce_4x && i_tx_ready) begin
          text_d = text_q << 8;
          rem_d  = rem_q - 6'd1;
          if (rem_q == 6'd1) state_d = ST_DAT_WAIT;
        end
      end

      ST_DAT_WAIT: begin
        if (i_spi_ce_4x && i_spi_idle) state_d = ST_IDLE;
      end

      default: state_d = ST_BOOT;
    endcase
  end

  // State and auxiliary registers; reset overrides the clock enable
  always_ff @(posedge i_ext_spi_clk_x or posedge i_srst) begin
    if (i_srst) begin
      state_q   <= ST_BOOT;
      timer_q   <= '0;
      cmd_q     <= '0;
      cmd_len_q <= '0;
      text_q    <= '0;
      rem_q     <= '0;
      n_q       <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      cmd_q     <= cmd_d;
      cmd_len_q <= cmd_len_d;
      text_q    <= text_d;
      rem_q     <= rem_d;
      n_q       <= n_d;
      err_q     <= err_d;
    end
  end

  assign o_command_ready = (state_q == ST_IDLE);
  assign o_cmd_error     = err_q;
  assign o_rx_len        = 8'h00;
  assign o_wait_cyc      = 8'h00;
  assign o_rx_dequeue    = 1'b0;

endmodule

// File: tb/tb_pmod_cls_multi_spi_solo.sv
// Bench for pmod_cls_multi_spi_solo: scoreboard of expected TX bytes checked by a byte monitor,
// plus per-scenario checks of ready/error/reset behaviour. Fast-sim boot is 5000 enables.
module tb_pmod_cls_multi_spi_solo;
  localparam int LC      = 16;
  localparam int BOOT_EN = 5000;

  logic              i_ext_spi_clk_x = 1'b0;
  logic              i_srst, i_spi_ce_4x;
  logic              i_cmd_clear, i_cmd_write;
  logic [1:0]        i_row;
  logic [5:0]        i_col, i_len;
  logic [8*LC-1:0]   i_dat_ascii;
  logic              i_tx_ready, i_spi_idle;
  logic              o_command_ready, o_cmd_error, o_tx_enqueue, o_go_stand, o_rx_dequeue;
  logic [7:0]        o_tx_data, o_tx_len, o_rx_len, o_wait_cyc;

  always #5 i_ext_spi_clk_x = ~i_ext_spi_clk_x;

  pmod_cls_multi_spi_solo #(
    .parm_fast_simulation(1), .parm_FCLK_ce(2500000), .parm_lines(2), .parm_line_chars(LC)
  ) dut (
    .i_ext_spi_clk_x(i_ext_spi_clk_x), .i_srst(i_srst), .i_spi_ce_4x(i_spi_ce_4x),
    .o_command_ready(o_command_ready), .i_cmd_clear(i_cmd_clear), .i_cmd_write(i_cmd_write),
    .i_row(i_row), .i_col(i_col), .i_len(i_len), .i_dat_ascii(i_dat_ascii),
    .o_cmd_error(o_cmd_error), .o_tx_data(o_tx_data), .o_tx_enqueue(o_tx_enqueue),
    .i_tx_ready(i_tx_ready), .o_tx_len(o_tx_len), .o_go_stand(o_go_stand),
    .o_rx_len(o_rx_len), .o_wait_cyc(o_wait_cyc), .o_rx_dequeue(o_rx_dequeue),
    .i_spi_idle(i_spi_idle)
  );

  typedef struct packed { logic [7:0] dat; logic go; logic [7:0] len; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int   n_pass = 0, n_total = 0;
  int   ce_div = 8;
  int   err_seen = 0, enq_seen = 0;
  bit   stall_mode = 1'b0;

  // Byte monitor: every enqueue on an enable cycle is compared with the scoreboard head
  always @(negedge i_ext_spi_clk_x) begin
    if (i_spi_ce_4x && !i_srst) begin
      if (o_cmd_error) err_seen++;
      if (o_tx_enqueue) begin
        enq_seen++;
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_byte: got dat=%h go=%b len=%0d, expected no byte", o_tx_data, o_go_stand, o_tx_len);
        end else begin
          mon_e = exp_q.pop_front();
          if ({o_tx_data, o_go_stand, o_tx_len} !== mon_e)
            $display("FAIL tx_byte: got dat=%h go=%b len=%0d, want dat=%h go=%b len=%0d",
                     o_tx_data, o_go_stand, o_tx_len, mon_e.dat, mon_e.go, mon_e.len);
          else n_pass++;
        end
      end
    end
  end

  task automatic ce_step();
    i_spi_ce_4x = 1'b1;
    @(posedge i_ext_spi_clk_x); #1;
    i_spi_ce_4x = 1'b0;
    for (int i = 1; i < ce_div; i++) begin
      @(posedge i_ext_spi_clk_x); #1;
    end
  endtask

  task automatic push(input logic [7:0] dat, input logic go, input int len);
    exp_t e;
    e.dat = dat; e.go = go; e.len = 8'(len);
    exp_q.push_back(e);
  endtask

  // Step enables until the scoreboard drains to 'target'; an expired budget is a failure
  task automatic run_until(input int target, input int budget, input string tag);
    int k = 0;
    while (exp_q.size() > target && k < budget) begin
      if (stall_mode) i_tx_ready = ~i_tx_ready;
      ce_step();
      k++;
    end
    i_tx_ready = 1'b1;
    if (exp_q.size() > target) begin
      n_total++;
      $display("FAIL %s_timeout: %0d bytes pending, want %0d", tag, exp_q.size(), target);
    end
  endtask

  task automatic push_clear();
    push(8'h1B, 1'b0, 4); push(8'h5B, 1'b0, 4); push(8'h30, 1'b0, 4); push(8'h6A, 1'b1, 4);
  endtask

  task automatic push_write(input int row, input int col, input int len, input logic [8*LC-1:0] txt, output int n);
    logic [7:0] c;
    n = (len > LC - col) ? LC - col : len;
    push(8'h1B, 1'b0, 7); push(8'h5B, 1'b0, 7); push(8'(8'h30 + row), 1'b0, 7); push(8'h3B, 1'b0, 7);
    push(8'(8'h30 + col / 10), 1'b0, 7); push(8'(8'h30 + col % 10), 1'b0, 7); push(8'h48, 1'b1, 7);
    for (int k = 0; k < n; k++) begin
      c = txt[8*(LC-col-k)-1 -: 8];
      push(c, k == n - 1, n);
    end
  endtask

  task automatic start_write(input int row, input int col, input int len, input logic [8*LC-1:0] txt);
    i_row = 2'(row); i_col = 6'(col); i_len = 6'(len); i_dat_ascii = txt;
    i_cmd_write = 1'b1;
    ce_step();
    i_cmd_write = 1'b0;
    ce_step();
    // inputs after the snapshot must not matter
    i_row = ~i_row; i_col = 6'($urandom); i_len = 6'($urandom);
    i_dat_ascii = {4{$urandom}};
  endtask

  task automatic finish_write(input int n, input bit stall, input string tag);
    stall_mode = stall;
    run_until(n, 200, tag);
    n_total++;
    if (o_command_ready !== 1'b0) $display("FAIL %s_cmdwait_ready: got %b want 0", tag, o_command_ready); else n_pass++;
    ce_step();
    n_total++;
    if (o_tx_enqueue !== 1'b0 || o_tx_len !== 8'd0) $display("FAIL %s_cmdwait_idle_out: got enq=%b len=%0d want 0/0", tag, o_tx_enqueue, o_tx_len); else n_pass++;
    i_spi_idle = 1'b1; ce_step(); i_spi_idle = 1'b0;
    run_until(0, 200, tag);
    stall_mode = 1'b0;
    ce_step();
    n_total++;
    if (o_command_ready !== 1'b0) $display("FAIL %s_datwait_ready: got %b want 0", tag, o_command_ready); else n_pass++;
    i_spi_idle = 1'b1; ce_step(); i_spi_idle = 1'b0;
    n_total++;
    if (o_command_ready !== 1'b1) $display("FAIL %s_done_ready: got %b want 1", tag, o_command_ready); else n_pass++;
  endtask

  task automatic do_clear(input string tag);
    int e0;
    e0 = err_seen;
    push_clear();
    // an invalid write alongside the clear: clear must win and no error may appear
    i_cmd_clear = 1'b1; i_cmd_write = 1'b1; i_row = 2'd2; i_col = 6'd0; i_len = 6'd4;
    ce_step();
    i_cmd_clear = 1'b0; i_cmd_write = 1'b0;
    n_total++;
    if (o_command_ready !== 1'b0) $display("FAIL %s_ack: ready got %b want 0", tag, o_command_ready); else n_pass++;
    run_until(0, 50, tag);
    ce_step();
    n_total++;
    if (o_command_ready !== 1'b0) $display("FAIL %s_wait_ready: got %b want 0", tag, o_command_ready); else n_pass++;
    i_spi_idle = 1'b1; ce_step(); i_spi_idle = 1'b0;
    n_total++;
    if (o_command_ready !== 1'b1) $display("FAIL %s_done_ready: got %b want 1", tag, o_command_ready); else n_pass++;
    n_total++;
    if (err_seen !== e0) $display("FAIL %s_no_error: got %0d error pulses want 0", tag, err_seen - e0); else n_pass++;
  endtask

  task automatic wait_boot(input string tag);
    repeat (BOOT_EN - 1) ce_step();
    n_total++;
    if (o_command_ready !== 1'b0) $display("FAIL %s_early: ready got %b want 0", tag, o_command_ready); else n_pass++;
    ce_step();
`ifdef PMOD_CLS_BOOT_CLEAR_EN
    n_total++;
    if (o_command_ready !== 1'b0) $display("FAIL %s_initclr_ready: got %b want 0", tag, o_command_ready); else n_pass++;
    push_clear();
    run_until(0, 50, tag);
    n_total++;
    if (o_command_ready !== 1'b0) $display("FAIL %s_initwait_ready: got %b want 0", tag, o_command_ready); else n_pass++;
    i_spi_idle = 1'b1; ce_step(); i_spi_idle = 1'b0;
`endif
    n_total++;
    if (o_command_ready !== 1'b1) $display("FAIL %s_ready: got %b want 1", tag, o_command_ready); else n_pass++;
  endtask

  task automatic test_reset();
    @(posedge i_ext_spi_clk_x); #1;
    i_spi_ce_4x = 1'b1; #1;
    n_total++;
    if ({o_command_ready, o_cmd_error, o_tx_enqueue, o_go_stand, o_rx_dequeue} !== 5'b0)
      $display("FAIL reset_flags: got %b want 00000", {o_command_ready, o_cmd_error, o_tx_enqueue, o_go_stand, o_rx_dequeue});
    else n_pass++;
    n_total++;
    if ({o_tx_data, o_tx_len, o_rx_len, o_wait_cyc} !== 32'h0)
      $display("FAIL reset_buses: got %h want 0", {o_tx_data, o_tx_len, o_rx_len, o_wait_cyc});
    else n_pass++;
    @(posedge i_ext_spi_clk_x); #1;
    i_spi_ce_4x = 1'b0;
    i_srst = 1'b0;
    ce_div = 8;
    wait_boot("boot");
    ce_div = 2;
  endtask

  task automatic test_clear();
    do_clear("clear");
    n_total++;
    if ({o_tx_data, o_tx_len, o_go_stand, o_tx_enqueue} !== 18'h0)
      $display("FAIL clear_idle_out: got %h want 0", {o_tx_data, o_tx_len, o_go_stand, o_tx_enqueue});
    else n_pass++;
  endtask

  task automatic test_write_basic();
    int n;
    logic [8*LC-1:0] t;
    t = "ABCDEFGHIJKLMNOP";
    push_write(1, 12, 16, t, n);
    n_total++;
    if (n !== 4) $display("FAIL write_basic_clip: got %0d want 4", n); else n_pass++;
    start_write(1, 12, 16, t);
    finish_write(n, 1'b0, "write_basic");
  endtask

  task automatic test_write_edges();
    int rows[3] = '{0, 1, 0};
    int cols[3] = '{0, 15, 5};
    int lens[3] = '{3, 1, 63};
    int n;
    logic [8*LC-1:0] t;
    t = "HELLO WORLD 1234";
    for (int i = 0; i < 3; i++) begin
      push_write(rows[i], cols[i], lens[i], t, n);
      start_write(rows[i], cols[i], lens[i], t);
      finish_write(n, 1'b0, "write_edge");
    end
  endtask

  task automatic test_reject();
    int rows[3] = '{2, 0, 1};
    int cols[3] = '{0, 16, 3};
    int lens[3] = '{4, 4, 0};
    int e0, q0;
    for (int i = 0; i < 3; i++) begin
      e0 = err_seen; q0 = enq_seen;
      i_row = 2'(rows[i]); i_col = 6'(cols[i]); i_len = 6'(lens[i]);
      i_cmd_write = 1'b1;
      ce_step();
      i_cmd_write = 1'b0;
      ce_step(); ce_step();
      n_total++;
      if (err_seen - e0 !== 1) $display("FAIL reject_err_pulses: got %0d want 1", err_seen - e0); else n_pass++;
      n_total++;
      if (enq_seen !== q0) $display("FAIL reject_no_enqueue: got %0d bytes want 0", enq_seen - q0); else n_pass++;
      n_total++;
      if (o_command_ready !== 1'b1) $display("FAIL reject_ready: got %b want 1", o_command_ready); else n_pass++;
    end
  endtask

  task automatic test_stall();
    int n;
    logic [8*LC-1:0] t;
    t = "0123456789abcdef";
    push_write(0, 0, 16, t, n);
    start_write(0, 0, 16, t);
    // requests raised while busy must be dropped, not queued
    i_cmd_clear = 1'b1;
    stall_mode = 1'b1;
    run_until(n, 200, "stall_cmd");
    i_cmd_clear = 1'b0;
    finish_write(n, 1'b1, "stall");
    n_total++;
    if (exp_q.size() !== 0) $display("FAIL stall_drained: got %0d pending want 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int n;
    logic [8*LC-1:0] t;
    t = "back to back  ok";
    do_clear("b2b_clear");
    push_write(1, 3, 5, t, n);
    start_write(1, 3, 5, t);
    finish_write(n, 1'b0, "b2b_write1");
    push_write(0, 10, 9, t, n);
    start_write(0, 10, 9, t);
    finish_write(n, 1'b0, "b2b_write2");
  endtask

  task automatic test_reset_mid();
    int n;
    logic [8*LC-1:0] t;
    t = "RESET MIDSTREAM!";
    push_write(0, 0, 16, t, n);
    start_write(0, 0, 16, t);
    run_until(n, 100, "rstmid_cmd");
    i_spi_idle = 1'b1; ce_step(); i_spi_idle = 1'b0;
    run_until(n - 2, 100, "rstmid_dat");
    n_total++;
    if (o_tx_enqueue !== 1'b1 || o_tx_data !== exp_q[0].dat)
      $display("FAIL rstmid_third_byte: got enq=%b dat=%h want 1/%h", o_tx_enqueue, o_tx_data, exp_q[0].dat);
    else n_pass++;
    i_srst = 1'b1; #1;
    n_total++;
    if ({o_command_ready, o_cmd_error, o_tx_enqueue, o_go_stand, o_tx_data, o_tx_len} !== 20'h0)
      $display("FAIL rstmid_outputs: got %h want 0", {o_command_ready, o_cmd_error, o_tx_enqueue, o_go_stand, o_tx_data, o_tx_len});
    else n_pass++;
    exp_q.delete();
    repeat (3) ce_step();
    n_total++;
    if (o_command_ready !== 1'b0 || o_tx_enqueue !== 1'b0) $display("FAIL rstmid_held: got rdy=%b enq=%b want 0/0", o_command_ready, o_tx_enqueue); else n_pass++;
    i_srst = 1'b0;
    ce_div = 1;
    wait_boot("reboot");
    ce_div = 2;
    push_write(1, 14, 5, t, n);
    start_write(1, 14, 5, t);
    finish_write(n, 1'b0, "post_reset_write");
  endtask

  initial begin
    i_srst = 1'b1; i_spi_ce_4x = 1'b0; i_cmd_clear = 1'b0; i_cmd_write = 1'b0;
    i_row = '0; i_col = '0; i_len = '0; i_dat_ascii = '0;
    i_tx_ready = 1'b1; i_spi_idle = 1'b0;
    test_reset();
    test_clear();
    test_write_basic();
    test_write_edges();
    test_reject();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pmod_cls_multi_spi_solo.md
PMOD_CLS_MULTI_SPI_SOLO -- requirements
Module: pmod_cls_multi_spi_solo

Interface
REQ-001 SHALL have parameter parm_fast_simulation, default 0: nonzero shortens boot wait to 2 ms.
REQ-002 SHALL have parameter parm_FCLK_ce, default 2500000: frequency in Hz of i_spi_ce_4x pulses.
REQ-003 SHALL have parameter parm_lines, default 2: display rows, legal 1..4.
REQ-004 SHALL have parameter parm_line_chars, default 16: characters per row, legal 1..40.
REQ-005 i_ext_spi_clk_x  in  1  sole clock.
REQ-006 i_srst  in  1  reset, asynchronous, active-high.
REQ-007 i_spi_ce_4x  in  1  clock enable; all state, timer and aux registers advance only when high.
REQ-008 o_command_ready  out  1  high only in IDLE.
REQ-009 i_cmd_clear  in  1  request display clear.
REQ-010 i_cmd_write  in  1  request text write.
REQ-011 i_row  in  2  target row, 0-based.
REQ-012 i_col  in  6  start column, 0-based.
REQ-013 i_len  in  6  characters to send.
REQ-014 i_dat_ascii  in  8*parm_line_chars  text; character 0 in the MSBs.
REQ-015 o_cmd_error  out  1  one-enable-cycle pulse on a rejected write.
REQ-016 o_tx_data  out  8  byte to the SPI TX FIFO.
REQ-017 o_tx_enqueue  out  1  enqueue strobe.
REQ-018 i_tx_ready  in  1  TX FIFO can accept.
REQ-019 o_tx_len  out  8  byte count of the current SPI transfer.
REQ-020 o_go_stand  out  1  start standard SPI transfer.
REQ-021 i_spi_idle  in  1  SPI engine idle.
REQ-022 o_rx_len, o_wait_cyc (8 each) and o_rx_dequeue SHALL be constant 0.

Function
REQ-023 FSM states SHALL be BOOT, INIT_CLR, IDLE, LOAD_CLR, LOAD_TXT, CMD_RUN, CMD_WAIT, DAT_RUN and DAT_WAIT; unreachable encodings SHALL go to BOOT.
REQ-024 BOOT SHALL hold for parm_FCLK_ce/1000*800 enable cycles (or *2 when fast) on a 24-bit timer, then exit.
REQ-025 In IDLE with i_spi_ce_4x high, i_cmd_clear SHALL take priority over i_cmd_write; requests outside IDLE SHALL be ignored, not queued.
REQ-026 Clear SHALL send 4 bytes: 0x1B 0x5B 0x30 0x6A, as one transfer with o_tx_len=4 and no data phase.
REQ-027 Write SHALL send 7 bytes: 0x1B 0x5B, 0x30+row, 0x3B, column tens digit, column ones digit (ASCII), 0x48, with o_tx_len=7.
REQ-028 Write data SHALL be i_dat_ascii characters i_col .. i_col+n-1, sent as a second transfer with o_tx_len=n.
REQ-029 n SHALL be i_len clipped to parm_line_chars-i_col.
REQ-030 A write with i_row>=parm_lines, i_col>=parm_line_chars or i_len=0 SHALL be rejected: o_cmd_error pulses, FSM stays in IDLE, and nothing is sent.
REQ-031 Row, column, n and text SHALL be latched in LOAD_TXT; later input changes SHALL NOT affect the transfer.
REQ-032 In RUN states, o_tx_enqueue SHALL equal i_tx_ready; each accepted byte SHALL decrement the remaining count.
REQ-033 o_go_stand SHALL assert together with the enqueue of the last byte only.
REQ-034 A WAIT state SHALL exit on i_spi_idle: CMD_WAIT to DAT_RUN when n>0, otherwise to IDLE; DAT_WAIT to IDLE.
REQ-035 A stalled i_tx_ready SHALL hold the RUN state, byte index and outputs unchanged.
REQ-036 When not in a RUN state, o_tx_data, o_tx_enqueue, o_tx_len and o_go_stand SHALL be 0.

Reset
REQ-037 i_srst SHALL force BOOT, clear the timer and all aux registers, and drive all outputs to 0, regardless of i_spi_ce_4x.
REQ-038 Reset mid-transfer SHALL abandon the transfer and restart the full boot wait.

Configuration
REQ-039 With macro PMOD_CLS_BOOT_CLEAR_EN defined, BOOT SHALL exit to INIT_CLR, which issues the REQ-026 clear sequence and then reaches IDLE through CMD_WAIT; o_command_ready SHALL stay low throughout.
REQ-040 Without PMOD_CLS_BOOT_CLEAR_EN, BOOT SHALL exit directly to IDLE and INIT_CLR SHALL be absent.

Verification
REQ-041 Fast sim, ce every 8 clocks: o_command_ready SHALL rise 5000 enables after reset (macro off), or after one 4-byte clear transfer (macro on).
REQ-042 Clear request: bytes 1B 5B 30 6A with o_go_stand on the 4th byte and o_tx_len=4; ready SHALL return after i_spi_idle.
REQ-043 Write row=1, col=12, len=16, text "ABCDEFGHIJKLMNOP": command bytes 1B 5B 31 3B 31 32 48, then data "MNOP" with o_tx_len=4.
REQ-044 Write row=2 with parm_lines=2: o_cmd_error pulses once, no enqueue, o_command_ready stays high.
REQ-045 i_tx_ready toggled low every other enable during a 16-character write: byte order and count SHALL be intact.
REQ-046 i_srst asserted on the 3rd data byte: all outputs SHALL be 0 immediately, and the boot wait SHALL restart.
